// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM generator/capture types and default widths
//
// Purpose: capture FSM state encoding and the counter/divider widths that the
//          PWM generator and pwm_capture agree on.
// Ports:   none (package).

package pwm_pkg;

   localparam int PWM_CNT_W = 16;
   localparam int PWM_DIV_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pwm_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - pin synchronizer with rise/fall edge detection
//
// Purpose: brings an asynchronous pin into the clock domain and flags edges.
// Ports:
//   clock   input   system clock
//   reset   input   asynchronous, active-high
//   pin_i   input   asynchronous pin
//   rise_o  output  synchronized level went 0 -> 1 this cycle
//   fall_o  output  synchronized level went 1 -> 0 this cycle

module pwm_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic pin_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   level;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level  = sync_q[SYNC_STAGES-1];
   assign rise_o = level & ~hist_q;
   assign fall_o = ~level & hist_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM input capture: high time and period in prescaled ticks
//
// Purpose: measures the high time and period of an external PWM pin in ticks of
//          div clocks, reporting both on a one-cycle valid strobe.
// Ports:
//   clock        input   system clock
//   reset        input   asynchronous, active-high
//   pwm_in       input   asynchronous PWM pin
//   enable       input   capture enable
//   div          input   clocks per tick, 0 disables capture
//   ovf_clear    input   clears the sticky overflow flag
//   high_count   output  last completed high time, ticks
//   period_count output  last completed period, ticks
//   valid        output  one-cycle pulse when both counts update
//   ovf          output  sticky period overflow

module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W       = PWM_CNT_W,
   parameter int DIV_W       = PWM_DIV_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pwm_in,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   input  logic             ovf_clear,
   output logic [CNT_W-1:0] high_count,
   output logic [CNT_W-1:0] period_count,
   output logic             valid,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   logic rise;
   logic fall;

   pwm_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_edge_sync (
      .clock (clock),
      .reset (reset),
      .pin_i (pwm_in),
      .rise_o(rise),
      .fall_o(fall)
   );

   pwm_state_t       state_q, state_d;
   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] p_q, p_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic [DIV_W-1:0] pcnt_q, pcnt_d;

   logic             active;
   logic [DIV_W-1:0] phase;
   logic             tick;
   logic             p_full;
   logic             ovf_set;

   assign active = enable && (div != '0);

   // A rising edge restarts the prescaler so tick boundaries line up with the
   // start of each period, which gives ceil() semantics on the counts.
   assign phase  = rise ? '0 : pcnt_q;
   assign tick   = active && (phase == '0);
   assign pcnt_d = !active ? '0 : ((phase == div - DIV_ONE) ? '0 : phase + DIV_ONE);
   assign p_full = (p_q == '1);

   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      p_d      = p_q;
      high_d   = high_q;
      period_d = period_q;
      valid_d  = 1'b0;
      ovf_set  = 1'b0;

      if (!active) begin
         state_d = IDLE;
         h_d     = '0;
         p_d     = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d = HIGH;
                  h_d     = CNT_ONE;
                  p_d     = CNT_ONE;
               end
            end
            HIGH: begin
               if (fall) state_d = LOW;
               if (tick) begin
                  if (p_full) begin
                     ovf_set = 1'b1;
                  end else begin
                     p_d = p_q + CNT_ONE;
                     // The fall cycle belongs to the low phase, so H stops here.
                     if (!fall) h_d = h_q + CNT_ONE;
                  end
               end
            end
            LOW: begin
               if (rise) begin
                  high_d   = h_q;
                  period_d = p_q;
                  valid_d  = 1'b1;
                  h_d      = CNT_ONE;
                  p_d      = CNT_ONE;
                  state_d  = HIGH;
               end else if (tick) begin
                  if (p_full) ovf_set = 1'b1;
                  else        p_d = p_q + CNT_ONE;
               end
            end
            default: state_d = IDLE;
         endcase

         // A period too long to represent is discarded; published counts hold.
         if (ovf_set) begin
            state_d = IDLE;
            h_d     = '0;
            p_d     = '0;
         end
      end

      ovf_d = ovf_set | (ovf_q & ~ovf_clear);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         h_q      <= '0;
         p_q      <= '0;
         high_q   <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         pcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         p_q      <= p_d;
         high_q   <= high_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         pcnt_q   <= pcnt_d;
      end
   end

   assign high_count   = high_q;
   assign period_count = period_q;
   assign valid        = valid_q;
   assign ovf          = ovf_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture

module tb_pwm_capture;

   localparam int CNT_W = 16;
   localparam int DIV_W = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             pwm_in;
   logic             enable;
   logic [DIV_W-1:0] div;
   logic             ovf_clear;
   logic [CNT_W-1:0] high_count;
   logic [CNT_W-1:0] period_count;
   logic             valid;
   logic             ovf;

   pwm_capture #(
      .CNT_W(CNT_W),
      .DIV_W(DIV_W),
      .SYNC_STAGES(2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .pwm_in      (pwm_in),
      .enable      (enable),
      .div         (div),
      .ovf_clear   (ovf_clear),
      .high_count  (high_count),
      .period_count(period_count),
      .valid       (valid),
      .ovf         (ovf)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int step_no = 0;
   int valid_cnt = 0;
   int last_valid = -1;
   int exp_gap = 20;
   int first_ovf = -1;
   logic [CNT_W-1:0] exp_h = '0;
   logic [CNT_W-1:0] exp_p = '0;
   logic [CNT_W-1:0] hold_h = '0;
   logic [CNT_W-1:0] hold_p = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic new_section(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] p);
      valid_cnt  = 0;
      last_valid = -1;
      exp_h      = h;
      exp_p      = p;
   endtask

   // One clock: drive the pin, sample #1 after the edge, check counts/hold.
   task automatic step(input logic pin);
      pwm_in = pin;
      @(posedge clock);
      #1;
      step_no++;
      if (valid) begin
         valid_cnt++;
         check("high_count", 32'(high_count), 32'(exp_h));
         check("period_count", 32'(period_count), 32'(exp_p));
         if (last_valid >= 0) check("valid_gap", step_no - last_valid, exp_gap);
         last_valid = step_no;
         hold_h = exp_h;
         hold_p = exp_p;
      end else begin
         check("hold_high", 32'(high_count), 32'(hold_h));
         check("hold_period", 32'(period_count), 32'(hold_p));
      end
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < hi; i++) step(1'b1);
         for (int i = 0; i < lo; i++) step(1'b0);
      end
   endtask

   task automatic regap(input logic [DIV_W-1:0] new_div);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0);
      div    = new_div;
      enable = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      pwm_in    = 1'b0;
      enable    = 1'b0;
      div       = 8'd1;
      ovf_clear = 1'b0;
      #12;
      check("rst_high", 32'(high_count), 0);
      check("rst_period", 32'(period_count), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_ovf", 32'(ovf), 0);
      @(negedge clock);
      reset = 1'b0;

      // div=1, 5 high / 15 low: four rises give three results
      regap(8'd1);
      new_section(16'd5, 16'd20);
      wave(5, 15, 4);
      check("t1_valids", valid_cnt, 3);

      // div=4: ceil(5/4)=2, ceil(20/4)=5
      regap(8'd4);
      new_section(16'd2, 16'd5);
      wave(5, 15, 4);
      check("t2_valids", valid_cnt, 3);

      // enable dropped mid-LOW: the partial period never reports
      regap(8'd1);
      new_section(16'd5, 16'd20);
      for (int i = 0; i < 5; i++) step(1'b1);
      for (int i = 0; i < 7; i++) step(1'b0);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0);
      enable = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b0);
      check("t4_no_partial", valid_cnt, 0);
      wave(5, 15, 3);
      check("t4_valids", valid_cnt, 2);

      // div=0: capture disabled, outputs hold 5/20
      regap(8'd0);
      new_section(16'd5, 16'd20);
      wave(5, 15, 3);
      check("t5_valids", valid_cnt, 0);

      // overflow: one rise then held high at div=1
      regap(8'd1);
      new_section(16'd5, 16'd20);
      check("t3_ovf_before", 32'(ovf), 0);
      for (int i = 0; i < 65545; i++) begin
         step(1'b1);
         if (ovf && first_ovf < 0) first_ovf = i;
      end
      check("t3_ovf_step", first_ovf, 65537);
      check("t3_ovf_set", 32'(ovf), 1);
      check("t3_valids", valid_cnt, 0);
      ovf_clear = 1'b1;
      step(1'b1);
      ovf_clear = 1'b0;
      check("t3_ovf_cleared", 32'(ovf), 0);
      step(1'b1);
      check("t3_ovf_stays_clear", 32'(ovf), 0);

      // asynchronous reset mid-HIGH
      regap(8'd1);
      for (int i = 0; i < 3; i++) step(1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_high", 32'(high_count), 0);
      check("t6_rst_period", 32'(period_count), 0);
      check("t6_rst_valid", 32'(valid), 0);
      check("t6_rst_ovf", 32'(ovf), 0);
      hold_h = '0;
      hold_p = '0;
      @(negedge clock);
      reset = 1'b0;
      new_section(16'd5, 16'd20);
      for (int i = 0; i < 3; i++) step(1'b0);
      wave(5, 15, 4);
      check("t6_valids", valid_cnt, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
